// File: rtl/prefetch_queue_pkg.sv
// Shared constants and helpers for the instruction prefetch front end.
package prefetch_queue_pkg;

    // Default geometry of the fetch path.
    localparam int PQ_NSHIFT         = 2;
    localparam int PQ_WORD_BITS      = 16;
    localparam int PQ_DEPTH          = 2;
    localparam int PQ_BEATS_PER_WORD = PQ_WORD_BITS / PQ_NSHIFT;

    // Phases of a TX/RX fetch transaction as seen by the bus side.
    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_CMD  = 2'd1,
        TX_DATA = 2'd2
    } tx_phase_e;

    // Requesters sharing the fetch path.
    typedef enum logic [1:0] {
        SRC_INST = 2'd0,
        SRC_IMM  = 2'd1,
        SRC_DATA = 2'd2
    } src_e;

    // Width of a counter that must hold 0 .. n-1 (never narrower than 1 bit).
    function automatic int beat_cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/prefetch_queue_word_fifo.sv
// Small register FIFO of fetched words with occupancy count and synchronous clear.
module prefetch_queue_word_fifo
    import prefetch_queue_pkg::*;
#(
    parameter int WIDTH = PQ_WORD_BITS,
    parameter int DEPTH = PQ_DEPTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = beat_cnt_width(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PW-1:0]    rd_ptr_reg;
    logic [PW-1:0]    wr_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic [DEPTH-1:0] wr_en;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_wr_en
            assign wr_en[gi] = push && (wr_ptr_reg == PW'(gi));
        end
    endgenerate

    // Entry storage: only the addressed slot captures the pushed word.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_en[i]) begin
                mem_reg[i] <= push_data;
            end
        end
    end

    // Pointer and occupancy bookkeeping; clear drops everything queued.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= next_ptr(wr_ptr_reg);
            end
            if (pop) begin
                rd_ptr_reg <= next_ptr(rd_ptr_reg);
            end
            if (push && !pop) begin
                count_reg <= count_reg + 1'b1;
            end else if (pop && !push) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end

    assign head  = mem_reg[rd_ptr_reg];
    assign count = count_reg;

    // Fetch control never requests a word that would not fit.
    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(push && !pop && !clear && (count_reg == CW'(DEPTH))));

endmodule

// File: rtl/prefetch_queue.sv
// Instruction prefetch front end: assembles serial fetch beats into words,
// queues them, and serves the decoder's instruction and immediate registers.
module prefetch_queue
    import prefetch_queue_pkg::*;
#(
    parameter int NSHIFT    = PQ_NSHIFT,
    parameter int WORD_BITS = PQ_WORD_BITS,
    parameter int DEPTH     = PQ_DEPTH
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 fetch_req,
    input  logic                 fetch_ack,
    input  logic                 fetch_data_valid,
    input  logic [NSHIFT-1:0]    fetch_data,
    input  logic                 flush,
    input  logic                 block_prefetch,
    output logic                 prefetch_idle,
    output logic                 inst_valid,
    output logic [WORD_BITS-1:0] inst,
    input  logic                 inst_done,
    input  logic                 load_imm16,
    output logic                 imm16_loaded,
    output logic [WORD_BITS-1:0] imm_full,
    output logic [NSHIFT-1:0]    imm_data,
    input  logic                 next_imm_data
);

    localparam int BEATS = WORD_BITS / NSHIFT;
    localparam int BW    = beat_cnt_width(BEATS);
    localparam int CW    = $clog2(DEPTH + 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);

    logic [BW-1:0]               beat_cnt_reg;
    logic [WORD_BITS-NSHIFT-1:0] asm_reg;
    logic                        in_flight_reg;
    logic                        discard_reg;
    logic [WORD_BITS-1:0]        inst_reg;
    logic                        inst_valid_reg;
    logic [WORD_BITS-1:0]        imm_reg;
    logic                        imm_loaded_reg;

    logic [WORD_BITS-1:0]        word_next;
    logic                        beat_accept;
    logic                        last_beat;
    logic                        q_push;
    logic                        q_pop;
    logic                        imm_pop;
    logic                        inst_pop;
    logic                        q_nonempty;
    logic [WORD_BITS-1:0]        q_head;
    logic [CW-1:0]               q_count;
    logic                        fetch_req_int;

    // Beats are LSB-first, so each new beat enters at the top of the word.
    assign word_next   = {fetch_data, asm_reg};
    // Stray beats with nothing in flight (e.g. after a reset) are ignored.
    assign beat_accept = fetch_data_valid && in_flight_reg;
    assign last_beat   = beat_accept && (beat_cnt_reg == LAST_BEAT);
    // A word that was in flight across a flush, or completes during one, is dropped.
    assign q_push      = last_beat && !discard_reg && !flush;

    assign q_nonempty  = (q_count != '0);
    // Immediate load wins over refill; it never coincides with inst_done so
    // at most one consumer pops per cycle. Nothing pops in a flush cycle
    // because the queued words belong to the old instruction stream.
    assign imm_pop  = !flush && load_imm16 && !imm_loaded_reg && inst_valid_reg
                      && !inst_done && q_nonempty;
    assign inst_pop = !flush && (!inst_valid_reg || inst_done) && q_nonempty && !imm_pop;
    assign q_pop    = imm_pop || inst_pop;

    assign fetch_req_int = !reset && !block_prefetch && !flush && !in_flight_reg
                           && (q_count < DEPTH_C);

    prefetch_queue_word_fifo #(
        .WIDTH (WORD_BITS),
        .DEPTH (DEPTH)
    ) u_word_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (flush),
        .push      (q_push),
        .push_data (word_next),
        .pop       (q_pop),
        .head      (q_head),
        .count     (q_count)
    );

    // Beat assembly plus in-flight / discard tracking for the outstanding word.
    // An in-flight word keeps counting through a flush so the bus transaction
    // still terminates on its 8th beat; only its contents are thrown away.
    always_ff @(posedge clk) begin
        if (reset) begin
            beat_cnt_reg  <= '0;
            asm_reg       <= '0;
            in_flight_reg <= 1'b0;
            discard_reg   <= 1'b0;
        end else begin
            if (beat_accept) begin
                asm_reg      <= word_next[WORD_BITS-1:NSHIFT];
                beat_cnt_reg <= last_beat ? '0 : beat_cnt_reg + 1'b1;
            end else if (flush && !in_flight_reg) begin
                beat_cnt_reg <= '0;
            end

            if (last_beat) begin
                in_flight_reg <= 1'b0;
            end else if (fetch_req_int && fetch_ack) begin
                in_flight_reg <= 1'b1;
            end

            if (last_beat) begin
                discard_reg <= 1'b0;
            end else if (flush && in_flight_reg) begin
                discard_reg <= 1'b1;
            end
        end
    end

    // Instruction register: refill from the queue head, or go empty on inst_done.
    always_ff @(posedge clk) begin
        if (reset) begin
            inst_reg       <= '0;
            inst_valid_reg <= 1'b0;
        end else if (inst_pop) begin
            inst_reg       <= q_head;
            inst_valid_reg <= 1'b1;
        end else if (inst_done) begin
            inst_valid_reg <= 1'b0;
        end
    end

    // Immediate register: load from the queue head, then stream out NSHIFT bits at a time.
    always_ff @(posedge clk) begin
        if (reset) begin
            imm_reg        <= '0;
            imm_loaded_reg <= 1'b0;
        end else begin
            if (imm_pop) begin
                imm_reg <= q_head;
            end else if (next_imm_data && imm_loaded_reg) begin
                imm_reg <= {{NSHIFT{1'b0}}, imm_reg[WORD_BITS-1:NSHIFT]};
            end

            if (imm_pop) begin
                imm_loaded_reg <= 1'b1;
            end else if (inst_done) begin
                imm_loaded_reg <= 1'b0;
            end
        end
    end

    assign fetch_req     = fetch_req_int;
    assign prefetch_idle = !reset && !in_flight_reg && !fetch_req_int;
    assign inst_valid    = inst_valid_reg;
    assign inst          = inst_reg;
    assign imm16_loaded  = imm_loaded_reg;
    assign imm_full      = imm_reg;
    assign imm_data      = imm_reg[NSHIFT-1:0];

endmodule
